// File: rtl/hilo_div_ctrl_pkg.sv
// Shared types and helpers for the HI/LO divide controller.
// Holds the FSM state encoding, default widths and sign/magnitude helpers.
package hilo_div_ctrl_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DIV_ITER  = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FIX    = 2'd3
  } div_state_e;

  // Two's-complement negate, modulo 2^WIDTH_DEF.
  function automatic logic [WIDTH_DEF-1:0] neg_val(input logic [WIDTH_DEF-1:0] x);
    return ~x + {{(WIDTH_DEF-1){1'b0}}, 1'b1};
  endfunction

  // Unsigned magnitude; the most negative value maps onto itself.
  function automatic logic [WIDTH_DEF-1:0] abs_val(input logic [WIDTH_DEF-1:0] x,
                                                   input logic is_signed);
    if (is_signed && x[WIDTH_DEF-1]) begin
      return neg_val(x);
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/hilo_div_ctrl.sv
// HI/LO divide controller: sequences an external unsigned iterative divider for
// DIV/DIVU, applies sign fix-up, and owns the architectural HI/LO registers.
module hilo_div_ctrl
  import hilo_div_ctrl_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int DIV_TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             stall,
  output logic             div_zero,
  output logic             div_timeout,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_busy,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r
);

  localparam int WCW = $clog2(DIV_TIMEOUT + 1);

  div_state_e       state_r, state_s;
  logic [WIDTH-1:0] a_mag_r, b_mag_r;
  logic             q_neg_r, r_neg_r;
  logic             seen_busy_r;
  logic [WCW-1:0]   wait_cnt_r;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             div_zero_r, div_timeout_r;
  logic             stall_s, start_s;
  logic             accept_s, zero_s, done_s, tmo_s;
  logic             sa_s, sb_s;

  assign sa_s     = op_signed & op_a[WIDTH-1];
  assign sb_s     = op_signed & op_b[WIDTH-1];
  assign accept_s = (state_r == ST_IDLE) && op_valid && (op_b != {WIDTH{1'b0}});
  assign zero_s   = (state_r == ST_IDLE) && op_valid && (op_b == {WIDTH{1'b0}});
  // Completion needs a busy phase first so a late-starting divider is not mistaken for done.
  assign done_s   = (state_r == ST_WAIT) && seen_busy_r && !div_busy;
  assign tmo_s    = (state_r == ST_WAIT) && !done_s && (wait_cnt_r == WCW'(DIV_TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, stall and start decode.
  always_comb begin
    state_s = state_r;
    stall_s = 1'b0;
    start_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_LAUNCH;
          stall_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_s = ST_WAIT;
        stall_s = 1'b1;
        start_s = 1'b1;
      end
      ST_WAIT: begin
        stall_s = 1'b1;
        if (done_s) begin
          state_s = ST_FIX;
        end else if (tmo_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_FIX: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Operand latch, busy tracking and watchdog counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_mag_r     <= {WIDTH{1'b0}};
      b_mag_r     <= {WIDTH{1'b0}};
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      seen_busy_r <= 1'b0;
      wait_cnt_r  <= {WCW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_mag_r <= abs_val(op_a, op_signed);
            b_mag_r <= abs_val(op_b, op_signed);
            q_neg_r <= sa_s ^ sb_s;
            r_neg_r <= sa_s;
          end
        end
        ST_LAUNCH: begin
          seen_busy_r <= 1'b0;
          wait_cnt_r  <= {WCW{1'b0}};
        end
        ST_WAIT: begin
          seen_busy_r <= seen_busy_r | div_busy;
          wait_cnt_r  <= wait_cnt_r + {{(WCW-1){1'b0}}, 1'b1};
        end
        default: begin
          seen_busy_r <= seen_busy_r;
        end
      endcase
    end
  end

  // Architectural HI/LO: moves only in IDLE, results only in FIX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else if (state_r == ST_IDLE) begin
      if (mthi_we) hi_r <= wdata;
      if (mtlo_we) lo_r <= wdata;
    end else if (state_r == ST_FIX) begin
      lo_r <= q_neg_r ? neg_val(div_q) : div_q;
      hi_r <= r_neg_r ? neg_val(div_r) : div_r;
    end
  end

  // Registered event pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_zero_r    <= 1'b0;
      div_timeout_r <= 1'b0;
    end else begin
      div_zero_r    <= zero_s;
      div_timeout_r <= tmo_s;
    end
  end

  assign hi           = hi_r;
  assign lo           = lo_r;
  assign stall        = stall_s & ~reset;
  assign div_start    = start_s;
  assign div_dividend = a_mag_r;
  assign div_divisor  = b_mag_r;
  assign div_zero     = div_zero_r;
  assign div_timeout  = div_timeout_r;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl with a behavioural 32-iteration divider
// that samples start and updates on the falling edge.
module tb_hilo_div_ctrl;

  localparam int W   = 32;
  localparam int TMO = 40;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         op_valid = 1'b0, op_signed = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic         mthi_we = 1'b0, mtlo_we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic [W-1:0] hi, lo, div_dividend, div_divisor, div_q, div_r;
  logic         stall, div_zero, div_timeout, div_start, div_busy;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  bit hang = 1'b0;
  int cnt;
  logic [W-1:0] da, db;

  hilo_div_ctrl #(.WIDTH(W), .DIV_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_signed(op_signed),
    .op_a(op_a), .op_b(op_b), .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .stall(stall), .div_zero(div_zero), .div_timeout(div_timeout),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_busy(div_busy), .div_q(div_q), .div_r(div_r)
  );

  always #5 clk = ~clk;

  // Divider model: start sampled on falling edge, done 32 falling edges later.
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      div_busy <= 1'b0;
      cnt      <= 0;
      div_q    <= '0;
      div_r    <= '0;
      da       <= '0;
      db       <= '0;
    end else if (div_start && !div_busy) begin
      div_busy <= 1'b1;
      cnt      <= 32;
      da       <= div_dividend;
      db       <= div_divisor;
    end else if (div_busy && !hang) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        div_busy <= 1'b0;
        div_q    <= da / db;
        div_r    <= da % db;
      end
    end
  end

  always @(negedge clk) if (div_start) start_cnt++;

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one op, counts stalled cycles, returns div_timeout seen as stall drops.
  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold, output int n, output logic to_end);
    n = 0;
    to_end = 1'b0;
    op_valid = 1'b1; op_signed = s; op_a = a; op_b = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!stall) begin
        to_end = div_timeout;
        break;
      end
      n++;
      @(posedge clk); #1;
      if (!hold) op_valid = 1'b0;
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  initial begin
    int n;
    int s0;
    logic te;

    #1;
    check_val("rst_hi", hi, 32'h0);
    check_val("rst_lo", lo, 32'h0);
    check_val("rst_stall", {31'd0, stall}, 32'd0);
    check_val("rst_start", {31'd0, div_start}, 32'd0);
    check_val("rst_flags", {30'd0, div_zero, div_timeout}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    s0 = start_cnt;
    run_op(1'b0, 32'd100, 32'd7, 1'b1, n, te);
    check_val("divu_stall", n, 32'd34);
    check_val("divu_start_once", start_cnt - s0, 32'd1);
    check_val("divu_lo", lo, 32'd14);
    check_val("divu_hi", hi, 32'd2);

    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, n, te);
    check_val("div_neg_lo", lo, 32'hFFFF_FFFD);
    check_val("div_neg_hi", hi, 32'hFFFF_FFFF);

    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, n, te);
    check_val("div_negb_lo", lo, 32'hFFFF_FFFD);
    check_val("div_negb_hi", hi, 32'd1);

    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, n, te);
    check_val("div_min_lo", lo, 32'h8000_0000);
    check_val("div_min_hi", hi, 32'h0);

    run_op(1'b0, 32'd5, 32'd0, 1'b1, n, te);
    check_val("dz_stall", n, 32'd0);
    check_val("dz_pulse", {31'd0, div_zero}, 32'd1);
    @(posedge clk); #1;
    check_val("dz_pulse_end", {31'd0, div_zero}, 32'd0);
    check_val("dz_lo", lo, 32'h8000_0000);
    check_val("dz_hi", hi, 32'h0);

    mtlo_we = 1'b1; wdata = 32'h55;
    @(posedge clk); #1 mtlo_we = 1'b0;
    check_val("mtlo_idle", lo, 32'h55);

    // MTHI with accepted op, then MTLO mid-WAIT.
    op_valid = 1'b1; op_signed = 1'b0; op_a = 32'd9; op_b = 32'd4;
    mthi_we = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1 mthi_we = 1'b0;
    @(negedge clk);
    check_val("mthi_same", hi, 32'h1234);
    repeat (8) @(posedge clk);
    #1 mtlo_we = 1'b1; wdata = 32'hDEAD;
    @(posedge clk); #1 mtlo_we = 1'b0;
    check_val("mtlo_wait_ign", lo, 32'h55);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall) break;
    end
    @(posedge clk); #1 op_valid = 1'b0;
    check_val("mthi_fix_hi", hi, 32'd1);
    check_val("mthi_fix_lo", lo, 32'd2);

    // Reset asserted during WAIT cycle 10, op_valid still high.
    op_valid = 1'b1; op_signed = 1'b0; op_a = 32'd1000; op_b = 32'd3;
    repeat (11) @(posedge clk);
    #1 check_val("pre_rst_stall", {31'd0, stall}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check_val("mid_rst_stall", {31'd0, stall}, 32'd0);
    check_val("mid_rst_hi", hi, 32'h0);
    check_val("mid_rst_lo", lo, 32'h0);
    op_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    repeat (40) @(posedge clk);
    #1 check_val("post_rst_lo", lo, 32'h0);

    // Watchdog: divider never finishes.
    mthi_we = 1'b1; wdata = 32'hAAAA;
    @(posedge clk); #1 mthi_we = 1'b0;
    hang = 1'b1;
    run_op(1'b0, 32'd50, 32'd5, 1'b0, n, te);
    check_val("tmo_stall", n, 32'(TMO + 2));
    check_val("tmo_pulse", {31'd0, te}, 32'd1);
    check_val("tmo_pulse_end", {31'd0, div_timeout}, 32'd0);
    check_val("tmo_hi", hi, 32'hAAAA);
    check_val("tmo_lo", lo, 32'h0);
    hang = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_div_ctrl.md
HILO_DIV_CTRL -- requirements
Module: hilo_div_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand/HI/LO width.
REQ-002 Parameter: DIV_TIMEOUT, 40, max WAIT cycles before abort.
REQ-003 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 op_valid  input  1  EX stage presents a DIV/DIVU; held while stall is high.
REQ-006 op_signed  input  1  1 = DIV (signed), 0 = DIVU.
REQ-007 op_a / op_b  input  WIDTH  dividend / divisor.
REQ-008 mthi_we / mtlo_we  input  1  write wdata to HI / LO.
REQ-009 wdata  input  WIDTH  MTHI/MTLO data.
REQ-010 hi / lo  output  WIDTH  architectural HI (remainder) / LO (quotient), registered.
REQ-011 stall  output  1  freeze pipeline, combinational.
REQ-012 div_zero  output  1  one-cycle pulse on divisor = 0.
REQ-013 div_timeout  output  1  one-cycle pulse on watchdog abort.
REQ-014 div_start / div_dividend / div_divisor  output  1/WIDTH/WIDTH  to unsigned iterative divider.
REQ-015 div_busy / div_q / div_r  input  1/WIDTH/WIDTH  from divider (updates on falling edge, busy for 32 iterations).

Function
REQ-016 FSM states SHALL be IDLE, LAUNCH, WAIT, FIX.
REQ-017 IDLE with op_valid and op_b != 0 SHALL latch op_a, op_b, op_signed, result signs, then go to LAUNCH.
REQ-018 IDLE with op_valid and op_b = 0 SHALL pulse div_zero, leave HI/LO unchanged, not assert stall, stay IDLE.
REQ-019 Signed ops SHALL drive div_dividend/div_divisor with magnitudes; 0x80000000 passes unchanged as its unsigned magnitude.
REQ-020 LAUNCH SHALL assert div_start for exactly one cycle, then go to WAIT; div_start low in every other state.
REQ-021 WAIT SHALL set a seen_busy flag when div_busy = 1 and go to FIX at the first edge with seen_busy = 1 and div_busy = 0.
REQ-022 WAIT exceeding DIV_TIMEOUT cycles SHALL pulse div_timeout, leave HI/LO unchanged, return to IDLE.
REQ-023 FIX SHALL write LO = quotient, negated when dividend sign XOR divisor sign; HI = remainder, negated when dividend negative; then go to IDLE.
REQ-024 Unsigned ops SHALL write div_q/div_r unmodified.
REQ-025 stall SHALL be high in IDLE when op_valid and op_b != 0, and in LAUNCH and WAIT; low in FIX, so the op retires on the edge that writes HI/LO.
REQ-026 With a divider that samples start on the falling edge of LAUNCH, stall SHALL be high exactly 34 cycles; HI/LO update at the end of cycle 35.
REQ-027 MTHI/MTLO SHALL write only in IDLE; in LAUNCH/WAIT/FIX they SHALL be ignored.
REQ-028 MTHI/MTLO simultaneous with an accepted op SHALL write this cycle; FIX later overwrites both.
REQ-029 Arithmetic SHALL be modulo 2^WIDTH; 0x80000000 / 0xFFFFFFFF signed yields LO = 0x80000000, HI = 0.

Reset
REQ-030 Reset SHALL force IDLE, hi = lo = 0, clear seen_busy and watchdog, and drive div_start, stall, div_zero, div_timeout low.
REQ-031 Reset mid-operation SHALL abandon the op without a HI/LO write; the divider shares the same reset.

Structure
REQ-032 Shared package SHALL hold the FSM state enum, WIDTH default, DIV_ITER = 32, and abs/negate helper functions.
REQ-033 No sub-module SHALL be required; the divider remains external, connected at the top level.

Verification
REQ-034 DIVU 100 / 7 -> stall 34 cycles, then LO = 14, HI = 2.
REQ-035 DIV 0xFFFFFFF9 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0; DIVU 5 / 0 -> div_zero pulse, HI/LO unchanged, no stall.
REQ-037 MTHI 0x1234 with DIVU 9 / 4 in the same cycle -> HI = 0x1234 next cycle, then HI = 1, LO = 2 after FIX; MTLO during WAIT ignored.
REQ-038 Reset asserted in WAIT cycle 10 -> hi = lo = 0, stall low immediately; a divider held busy -> div_timeout at DIV_TIMEOUT.
